// File: rtl/blake2s_pkg.sv
// Shared constants, widths and FSM state type for the BLAKE2s block sequencer.
package blake2s_pkg;

    localparam int BLOCK_BYTES = 64;
    localparam int MAX_KEY     = 32;
    localparam int MAX_OUT     = 32;

    localparam int IDX_W = 6;
    localparam int LEN_W = 64;
    localparam int KN_W  = 6;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT,
        S_KEY,
        S_KPAD,
        S_MSG,
        S_MPAD,
        S_HASH
    } state_t;

    function automatic logic cfg_legal(input logic [KN_W-1:0] kk, input logic [KN_W-1:0] nn);
        return (int'(kk) <= MAX_KEY) && (nn != '0) && (int'(nn) <= MAX_OUT);
    endfunction

endpackage

// File: rtl/blake2s_block_seq.sv
// Frames a byte stream (key then message) into zero-padded 64-byte blocks for
// the BLAKE2s core, paced by core readiness, and tracks the returned digest.
module blake2s_block_seq
    import blake2s_pkg::*;
(
    input  logic             clk,
    input  logic             nreset,
    input  logic             cfg_v_i,
    input  logic [KN_W-1:0]  kk_i,
    input  logic [KN_W-1:0]  nn_i,
    input  logic [LEN_W-1:0] ll_i,
    input  logic             in_v_i,
    input  logic [7:0]       in_data_i,
    output logic             in_ready_o,
    output logic [KN_W-1:0]  kk_o,
    output logic [KN_W-1:0]  nn_o,
    output logic [LEN_W-1:0] ll_o,
    output logic             data_v_o,
    output logic [7:0]       data_o,
    output logic [IDX_W-1:0] data_idx_o,
    output logic             block_first_o,
    output logic             block_last_o,
    input  logic             core_ready_i,
    input  logic             core_h_v_i,
    output logic             busy_o,
    output logic             done_o,
    output logic             err_o
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BLOCK_BYTES - 1);

    state_t             state;
    logic [IDX_W-1:0]   idx;
    logic [LEN_W-1:0]   rem;
    logic [KN_W-1:0]    hcnt;
    logic               first;
    logic               keyblk;
    logic               last;

    logic               fire;
    logic               emit;
    logic [7:0]         emit_byte;

    assign fire = in_v_i && in_ready_o;

    // NOTE: every variable assigned in always_comb gets a default first, so no latch is inferred.
    always_comb begin
        emit      = 1'b0;
        emit_byte = 8'h00;
        case (state)
            S_KEY, S_MSG: begin
                emit      = fire;
                emit_byte = in_data_i;
            end
            S_KPAD, S_MPAD: emit = 1'b1;
            default: ;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only, so every register sees pre-edge values.
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            state         <= S_IDLE;
            idx           <= '0;
            rem           <= '0;
            hcnt          <= '0;
            first         <= 1'b0;
            keyblk        <= 1'b0;
            last          <= 1'b0;
            in_ready_o    <= 1'b0;
            kk_o          <= '0;
            nn_o          <= '0;
            ll_o          <= '0;
            data_v_o      <= 1'b0;
            data_o        <= 8'h00;
            data_idx_o    <= '0;
            block_first_o <= 1'b0;
            block_last_o  <= 1'b0;
            busy_o        <= 1'b0;
            done_o        <= 1'b0;
            err_o         <= 1'b0;
        end else begin
            data_v_o <= 1'b0;
            done_o   <= 1'b0;
            err_o    <= 1'b0;

            // Every stream state shares the same byte launch; only the source differs.
            if (emit) begin
                data_v_o      <= 1'b1;
                data_o        <= emit_byte;
                data_idx_o    <= idx;
                block_first_o <= first;
                block_last_o  <= last;
                idx           <= idx + IDX_W'(1);
            end

            case (state)
                S_IDLE: begin
                    if (cfg_v_i) begin
                        if (!cfg_legal(kk_i, nn_i)) begin
                            err_o <= 1'b1;
                        end else begin
                            kk_o   <= kk_i;
                            nn_o   <= nn_i;
                            ll_o   <= ll_i;
                            rem    <= ll_i;
                            first  <= 1'b1;
                            keyblk <= (kk_i != '0);
                            hcnt   <= '0;
                            busy_o <= 1'b1;
                            state  <= S_WAIT;
                        end
                    end
                end

                S_WAIT: begin
                    if (core_ready_i) begin
                        idx <= '0;
                        if (keyblk) begin
                            last       <= (ll_o == '0);
                            in_ready_o <= 1'b1;
                            state      <= S_KEY;
                        end else if (rem == '0) begin
                            // Empty unkeyed job: a single all-zero block.
                            last  <= 1'b1;
                            state <= S_MPAD;
                        end else begin
                            last       <= (rem <= LEN_W'(BLOCK_BYTES));
                            in_ready_o <= 1'b1;
                            state      <= S_MSG;
                        end
                    end
                end

                S_KEY: begin
                    if (fire && (idx == kk_o - KN_W'(1))) begin
                        in_ready_o <= 1'b0;
                        state      <= S_KPAD;
                    end
                end

                S_KPAD: begin
                    if (idx == LAST_IDX) begin
                        first  <= 1'b0;
                        keyblk <= 1'b0;
                        state  <= last ? S_HASH : S_WAIT;
                    end
                end

                S_MSG: begin
                    if (fire) begin
                        rem <= rem - LEN_W'(1);
                        if (rem == LEN_W'(1)) begin
                            in_ready_o <= 1'b0;
                            state      <= (idx == LAST_IDX) ? S_HASH : S_MPAD;
                        end else if (idx == LAST_IDX) begin
                            in_ready_o <= 1'b0;
                            first      <= 1'b0;
                            state      <= S_WAIT;
                        end
                    end
                end

                S_MPAD: begin
                    if (idx == LAST_IDX) begin
                        state <= S_HASH;
                    end
                end

                S_HASH: begin
                    if (core_h_v_i) begin
                        if (hcnt == nn_o - KN_W'(1)) begin
                            done_o <= 1'b1;
                            busy_o <= 1'b0;
                            state  <= S_IDLE;
                        end else begin
                            hcnt <= hcnt + KN_W'(1);
                        end
                    end
                end

                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_blake2s_block_seq.sv
// Self-checking bench: block-level reference model of the framed byte stream.
module tb_blake2s_block_seq;

    logic        clk = 1'b0;
    logic        nreset;
    logic        cfg_v_i;
    logic [5:0]  kk_i;
    logic [5:0]  nn_i;
    logic [63:0] ll_i;
    logic        in_v_i;
    logic [7:0]  in_data_i;
    logic        in_ready_o;
    logic [5:0]  kk_o;
    logic [5:0]  nn_o;
    logic [63:0] ll_o;
    logic        data_v_o;
    logic [7:0]  data_o;
    logic [5:0]  data_idx_o;
    logic        block_first_o;
    logic        block_last_o;
    logic        core_ready_i;
    logic        core_h_v_i;
    logic        busy_o;
    logic        done_o;
    logic        err_o;

    always #5 clk = ~clk;

    blake2s_block_seq dut (
        .clk           (clk),
        .nreset        (nreset),
        .cfg_v_i       (cfg_v_i),
        .kk_i          (kk_i),
        .nn_i          (nn_i),
        .ll_i          (ll_i),
        .in_v_i        (in_v_i),
        .in_data_i     (in_data_i),
        .in_ready_o    (in_ready_o),
        .kk_o          (kk_o),
        .nn_o          (nn_o),
        .ll_o          (ll_o),
        .data_v_o      (data_v_o),
        .data_o        (data_o),
        .data_idx_o    (data_idx_o),
        .block_first_o (block_first_o),
        .block_last_o  (block_last_o),
        .core_ready_i  (core_ready_i),
        .core_h_v_i    (core_h_v_i),
        .busy_o        (busy_o),
        .done_o        (done_o),
        .err_o         (err_o)
    );

    typedef struct packed {
        logic [7:0] d;
        logic [5:0] idx;
        logic       first;
        logic       last;
    } beat_t;

    beat_t      exp_q[$];
    logic [7:0] stream[$];
    int         errors = 0;
    int         checks = 0;

    // Expected beats: optional key block, then message blocks, each zero-padded to 64.
    task automatic build_model(input int kk, input int ll);
        int    key_blks;
        int    msg_blks;
        int    total;
        beat_t b;
        exp_q.delete();
        key_blks = (kk != 0) ? 1 : 0;
        msg_blks = (ll + 63) / 64;
        if (kk == 0 && ll == 0) msg_blks = 1;
        total = key_blks + msg_blks;
        for (int blk = 0; blk < total; blk++) begin
            for (int i = 0; i < 64; i++) begin
                int off;
                if (blk < key_blks) begin
                    b.d = (i < kk) ? stream[i] : 8'h00;
                end else begin
                    off = (blk - key_blks) * 64 + i;
                    b.d = (off < ll) ? stream[kk + off] : 8'h00;
                end
                b.idx   = 6'(i);
                b.first = (blk == 0);
                b.last  = (blk == total - 1);
                exp_q.push_back(b);
            end
        end
    endtask

    task automatic fill_stream(input int n);
        stream.delete();
        for (int i = 0; i < n; i++) stream.push_back(8'($urandom));
    endtask

    task automatic idle_inputs();
        cfg_v_i      = 1'b0;
        in_v_i       = 1'b0;
        in_data_i    = 8'h00;
        core_h_v_i   = 1'b0;
        core_ready_i = 1'b0;
    endtask

    task automatic start_job(input int kk, input int nn, input int ll);
        @(negedge clk);
        cfg_v_i = 1'b1;
        kk_i    = 6'(kk);
        nn_i    = 6'(nn);
        ll_i    = 64'(ll);
        @(negedge clk);
        cfg_v_i = 1'b0;
        checks++;
        if ({busy_o, err_o, kk_o, nn_o, ll_o} !== {1'b1, 1'b0, 6'(kk), 6'(nn), 64'(ll)}) begin
            errors++;
            $display("FAIL cfg_accept: got busy=%0b err=%0b kk=%0d nn=%0d ll=%0d, required busy=1 err=0 kk=%0d nn=%0d ll=%0d",
                     busy_o, err_o, kk_o, nn_o, ll_o, kk, nn, ll);
        end
    endtask

    // Drives one job end to end. rnd randomises valid/ready/hash gaps and injects
    // stray hash pulses and ignored cfg strobes; hold parks core_ready low for 10
    // cycles after block 1; abort_at>0 returns after that many beats.
    task automatic run_job(input int kk, input int nn, input int ll,
                           input bit rnd, input bit hold, input int abort_at);
        int    pos;
        int    beats;
        int    pulses;
        int    hold_cnt;
        int    cyc;
        bit    fired;
        bit    exp_done;
        bit    held;
        bit    quiet;
        bit    aborted;
        beat_t got;
        beat_t want;
        build_model(kk, ll);
        start_job(kk, nn, ll);
        pos = 0; beats = 0; pulses = 0; hold_cnt = 0;
        fired = 0; exp_done = 0; held = 0; quiet = 0; aborted = 0;
        for (cyc = 0; cyc < 6000; cyc++) begin
            @(negedge clk);
            if (quiet) begin
                checks++;
                if (data_v_o !== 1'b0) begin
                    errors++;
                    $display("FAIL ready_low_quiet: got data_v=%0b, required 0", data_v_o);
                end
            end
            if (data_v_o === 1'b1) begin
                got = {data_o, data_idx_o, block_first_o, block_last_o};
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL extra_beat: got data=%02h idx=%0d, required no beat", data_o, data_idx_o);
                end else begin
                    want = exp_q.pop_front();
                    if (got !== want) begin
                        errors++;
                        $display("FAIL beat%0d: got data=%02h idx=%0d first=%0b last=%0b, required data=%02h idx=%0d first=%0b last=%0b",
                                 beats, got.d, got.idx, got.first, got.last, want.d, want.idx, want.first, want.last);
                    end
                end
                beats++;
            end
            checks++;
            if ({done_o, err_o, busy_o} !== {exp_done, 1'b0, !exp_done}) begin
                errors++;
                $display("FAIL status: got done=%0b err=%0b busy=%0b, required done=%0b err=0 busy=%0b",
                         done_o, err_o, busy_o, exp_done, !exp_done);
            end
            if (fired) pos++;
            if (pos == stream.size()) begin
                checks++;
                if (in_ready_o !== 1'b0) begin
                    errors++;
                    $display("FAIL ready_after_stream: got in_ready=%0b, required 0", in_ready_o);
                end
            end
            if (exp_done) break;
            if (abort_at > 0 && beats == abort_at) begin
                aborted = 1;
                break;
            end

            if (hold && !held && beats == 64) begin
                held     = 1;
                hold_cnt = 10;
            end
            quiet = (hold_cnt > 0);
            if (hold_cnt > 0) begin
                core_ready_i = 1'b0;
                hold_cnt--;
            end else begin
                core_ready_i = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
            end

            if (pos < stream.size() && (!rnd || $urandom_range(0, 3) != 0)) begin
                in_v_i    = 1'b1;
                in_data_i = stream[pos];
            end else begin
                in_v_i    = 1'b0;
                in_data_i = 8'($urandom);
            end
            fired = in_v_i && in_ready_o;

            if (exp_q.size() == 0 && pulses < nn && (!rnd || $urandom_range(0, 1) == 1)) begin
                core_h_v_i = 1'b1;
                pulses++;
                if (pulses == nn) exp_done = 1;
            end else begin
                core_h_v_i = (exp_q.size() != 0) && rnd && ($urandom_range(0, 7) == 0);
            end

            cfg_v_i = rnd && ($urandom_range(0, 7) == 0);
            kk_i    = 6'd40;
            nn_i    = 6'($urandom_range(1, 32));
            ll_i    = {$urandom, $urandom};
        end
        if (!aborted) idle_inputs();
        checks++;
        if (cyc >= 6000) begin
            errors++;
            $display("FAIL timeout: got no done after %0d cycles, required done", cyc);
        end else if (!aborted && exp_q.size() != 0) begin
            errors++;
            $display("FAIL missing_beats: got %0d beats short, required 0", exp_q.size());
        end else if ({kk_o, nn_o, ll_o} !== {6'(kk), 6'(nn), 64'(ll)}) begin
            errors++;
            $display("FAIL cfg_hold: got kk=%0d nn=%0d ll=%0d, required kk=%0d nn=%0d ll=%0d",
                     kk_o, nn_o, ll_o, kk, nn, ll);
        end
    endtask

    task automatic check_all_zero(input string name);
        checks++;
        if ({in_ready_o, kk_o, nn_o, ll_o, data_v_o, data_o, data_idx_o, block_first_o,
             block_last_o, busy_o, done_o, err_o} !== '0) begin
            errors++;
            $display("FAIL %s: got ready=%0b kk=%0d nn=%0d ll=%0d dv=%0b busy=%0b done=%0b err=%0b, required all 0",
                     name, in_ready_o, kk_o, nn_o, ll_o, data_v_o, busy_o, done_o, err_o);
        end
    endtask

    task automatic test_reset();
        idle_inputs();
        kk_i = '0; nn_i = '0; ll_i = '0;
        nreset = 1'b1;
        #2 nreset = 1'b0;
        repeat (3) @(negedge clk);
        check_all_zero("reset_state");
        nreset = 1'b1;
        @(negedge clk);
        check_all_zero("post_reset_idle");
    endtask

    task automatic test_short_msg();
        stream.delete();
        stream.push_back(8'h61);
        stream.push_back(8'h62);
        stream.push_back(8'h63);
        run_job(0, 32, 3, 0, 0, 0);
    endtask

    task automatic test_empty_msg();
        stream.delete();
        run_job(0, 32, 0, 0, 0, 0);
    endtask

    task automatic test_key_full_block();
        fill_stream(4 + 64);
        run_job(4, 16, 64, 0, 0, 0);
    endtask

    task automatic test_ready_gap();
        fill_stream(65);
        run_job(0, 32, 65, 0, 1, 0);
    endtask

    task automatic bad_cfg(input int kk, input int nn, input string name);
        @(negedge clk);
        cfg_v_i = 1'b1;
        kk_i    = 6'(kk);
        nn_i    = 6'(nn);
        ll_i    = 64'd999;
        @(negedge clk);
        cfg_v_i = 1'b0;
        checks++;
        if ({err_o, busy_o, kk_o, nn_o, ll_o} !== {1'b1, 1'b0, 6'd0, 6'd32, 64'd65}) begin
            errors++;
            $display("FAIL %s: got err=%0b busy=%0b kk=%0d nn=%0d ll=%0d, required err=1 busy=0 kk=0 nn=32 ll=65",
                     name, err_o, busy_o, kk_o, nn_o, ll_o);
        end
        @(negedge clk);
        checks++;
        if ({err_o, busy_o} !== 2'b00) begin
            errors++;
            $display("FAIL %s_pulse: got err=%0b busy=%0b, required err=0 busy=0", name, err_o, busy_o);
        end
    endtask

    // Runs right after test_ready_gap, whose config (0,32,65) must survive.
    task automatic test_bad_cfg();
        bad_cfg(33, 16, "bad_kk");
        bad_cfg(0, 0, "bad_nn_zero");
        bad_cfg(8, 33, "bad_nn_big");
    endtask

    task automatic test_back_to_back();
        int kk;
        int nn;
        int ll;
        for (int j = 0; j < 8; j++) begin
            kk = $urandom_range(0, 32);
            nn = $urandom_range(1, 32);
            case (j)
                0:       ll = 128;
                1:       ll = 0;
                default: ll = $urandom_range(0, 200);
            endcase
            fill_stream(kk + ll);
            run_job(kk, nn, ll, 1, 0, 0);
        end
    endtask

    task automatic test_reset_midjob();
        fill_stream(100);
        run_job(0, 32, 100, 0, 0, 21);
        nreset = 1'b0;
        #1;
        check_all_zero("async_reset");
        in_v_i       = 1'b1;
        core_ready_i = 1'b1;
        repeat (3) @(negedge clk);
        check_all_zero("held_reset");
        nreset = 1'b1;
        repeat (4) begin
            @(negedge clk);
            checks++;
            if ({data_v_o, in_ready_o, busy_o} !== 3'b000) begin
                errors++;
                $display("FAIL no_emit_after_reset: got dv=%0b ready=%0b busy=%0b, required 0 0 0",
                         data_v_o, in_ready_o, busy_o);
            end
        end
        idle_inputs();
        fill_stream(2 + 40);
        run_job(2, 8, 40, 1, 0, 0);
    endtask

    initial begin
        test_reset();
        test_short_msg();
        test_empty_msg();
        test_key_full_block();
        test_ready_gap();
        test_bad_cfg();
        test_back_to_back();
        test_reset_midjob();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/blake2s_block_seq.md
Name: blake2s_block_seq

Overview:
- Sequencer between the byte-wide host interface and the blake2s_hash256 core.
- Accepts a job configuration (kk, nn, ll) and a byte stream carrying the key followed by the message.
- Frames the stream into 64-byte blocks: zero-pads the key block and the final message block, and drives data_idx, block_first and block_last.
- Paces blocks on the core's ready handshake and counts the nn hash bytes returned to detect job completion.

Parameters:
- BLOCK_BYTES, 64, bytes per BLAKE2s block; fixes the data_idx width at 6.
- MAX_KEY, 32, largest legal kk.
- MAX_OUT, 32, largest legal nn.

Ports:
- clk  in  1  clock
- nreset  in  1  asynchronous active-low reset
- cfg_v_i  in  1  configuration strobe; sampled only in IDLE
- kk_i  in  6  key length in bytes
- nn_i  in  6  digest length in bytes
- ll_i  in  64  message length in bytes
- in_v_i  in  1  input byte valid
- in_data_i  in  8  input byte: key bytes first, then message bytes
- in_ready_o  out  1  sequencer accepts a byte this cycle
- kk_o  out  6  latched kk to the core
- nn_o  out  6  latched nn to the core
- ll_o  out  64  latched ll to the core
- data_v_o  out  1  byte valid to the core
- data_o  out  8  byte to the core
- data_idx_o  out  6  byte position within the current block
- block_first_o  out  1  current block is the first block; qualified by data_v_o
- block_last_o  out  1  current block is the last block; qualified by data_v_o
- core_ready_i  in  1  core can accept a new block
- core_h_v_i  in  1  core emits a hash byte
- busy_o  out  1  a job is in progress
- done_o  out  1  one-cycle pulse on the nn-th hash byte
- err_o  out  1  one-cycle pulse on an illegal configuration

Behaviour:
- Reset (asynchronous, any state):
  - All outputs go to 0; state goes to IDLE; counters clear.
  - A job in flight is discarded. No byte is emitted after reset deasserts until a new cfg_v_i is accepted.
- States: IDLE, WAIT, KEY, KPAD, MSG, MPAD, HASH.
- IDLE:
  - On cfg_v_i, check the configuration.
  - Illegal if kk>MAX_KEY, nn==0, or nn>MAX_OUT: pulse err_o the next cycle and stay in IDLE.
  - Legal: latch kk_o, nn_o and ll_o (held until the next accepted cfg); set rem=ll, first=1, keyblk=(kk!=0); set busy_o; go to WAIT.
- WAIT:
  - When core_ready_i=1: idx=0. Go to KEY if keyblk, otherwise to MSG.
  - On entering MSG, compute last = (rem<=64).
  - On entering KEY, compute last = (ll==0), so a key-only job sends one block.
- Byte-timing rules (all stream states):
  - in_ready_o=1 only in KEY or MSG.
  - A fire (in_v_i & in_ready_o) drives data_v_o=1 with data_o=in_data_i on the following cycle; data_idx_o=idx, then idx increments.
  - Gaps in in_v_i produce gaps in data_v_o; the core tolerates them, and data_idx_o never skips.
  - block_first_o and block_last_o are stable for every byte of a block.
- KEY: accept kk bytes; then go to KPAD if kk<64.
- KPAD:
  - Emit zero bytes, one per cycle with no input, until idx 63 is sent.
  - After byte 63: clear first and keyblk; go to WAIT, or to HASH if last.
- MSG:
  - Accept bytes and decrement rem on each fire.
  - If idx 63 is sent and rem>0: go to WAIT (next block, first cleared).
  - If rem reaches 0 with idx<63: go to MPAD.
  - If rem reaches 0 exactly at idx 63: go to HASH with no pad block.
- ll==0 and kk==0: MSG immediately becomes MPAD; one all-zero block is sent with first=last=1.
- MPAD: emit zeros through idx 63, then go to HASH.
- HASH:
  - in_ready_o=0. Count core_h_v_i pulses.
  - On pulse number nn: pulse done_o in the same cycle as that pulse is registered (one cycle after it); clear busy_o; go to IDLE.
  - core_h_v_i outside HASH is ignored.
- Arithmetic: rem is a 64-bit down-counter and never underflows. idx is 6 bits; it wraps only at a block boundary, where the state machine always leaves the stream state.
- cfg_v_i while busy is ignored, with no err_o.

Decomposition:
- Shared package blake2s_pkg:
  - BLOCK_BYTES, MAX_KEY, MAX_OUT.
  - State enum type.
  - Widths: IDX_W=6, LEN_W=64, KN_W=6.
- No sub-module. The FSM, idx counter, rem counter and hash-byte counter fit in one flat module (~250 lines).

Test Plan:
- kk=0, nn=32, ll=3, bytes 61 62 63, core_ready_i=1:
  - 64 data_v_o beats with idx 0..63; data is 61,62,63 then 61 zeros.
  - first=last=1 on every beat.
  - 32 core_h_v_i pulses give done_o one cycle after the 32nd.
- kk=0, nn=32, ll=0 -> one all-zero block, first=last=1; in_ready_o never asserts.
- kk=4, nn=16, ll=64 -> 128 beats:
  - Block 1: key then 60 zeros, first=1, last=0.
  - Block 2: 64 message bytes, first=0, last=1, no pad block.
  - done_o after 16 hash bytes.
- kk=0, nn=32, ll=65, core_ready_i low for 10 cycles between blocks:
  - No data_v_o while ready is low.
  - Block 2 is 1 byte plus 63 zeros, with last=1.
- cfg with kk=33, and separately with nn=0 -> err_o pulses once each; busy_o stays 0; kk_o/nn_o/ll_o are unchanged.
- nreset asserted at idx 20 of block 1 -> all outputs 0 immediately, state IDLE; a new cfg then starts cleanly with first=1 and idx=0.
